// File: rtl/conveng_pkg.sv
// Shared constants, entry type and scale/saturate helpers for outinf.
// OUTINF_ROUND_EN selects round-half-up ahead of the right shift.
package conveng_pkg;

  localparam int KS_DEF = 3;
  localparam int PB_DEF = 8;

  typedef struct packed {
    logic [PB_DEF-1:0] data;
    logic              last_x;
    logic              last_y;
  } fifo_ent_t;

  function automatic logic [31:0] out_dim(
    input logic [31:0] dim,
    input int          ks
  );
    return dim - 32'(ks) + 32'd1;
  endfunction

  function automatic logic [31:0] sat_shift(
    input logic [31:0] val,
    input int          shift,
    input int          pb
  );
    logic [32:0] sum;
    logic [32:0] s;
    logic [32:0] mx;
    sum = {1'b0, val};
`ifdef OUTINF_ROUND_EN
    if (shift > 0) sum = sum + (33'd1 << (shift - 1));
`endif
    s  = sum >> shift;
    mx = (33'd1 << pb) - 33'd1;
    return (s > mx) ? mx[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/outinf_fifo.sv
// First-word fall-through FIFO with a registered head entry.
// Async active-high reset; exposes full, empty and occupancy count.
module outinf_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          push, pop;

  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = head_q;
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign rd_nxt  = rd_q + 1'b1;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_nxt;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Head reloads from the new word only when it is about to be the oldest.
    if (push && (empty_o || (cnt_q == CW'(1) && pop)))
      head_d = wdata_i;
    else if (pop && cnt_q > CW'(1))
      head_d = mem_q[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/outinf.sv
// Output interface: scale/saturate results, tag frame position, buffer, done.
// Define OUTINF_ROUND_EN for round-half-up scaling (see conveng_pkg).
module outinf
  import conveng_pkg::*;
#(
  parameter int XB    = 10,
  parameter int YB    = 10,
  parameter int PB    = 8,
  parameter int KS    = KS_DEF,
  parameter int SHIFT = 3,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XB-1:0]   cfg_width,
  input  logic [YB-1:0]   cfg_height,
  input  logic [2*PB-1:0] pix_in,
  input  logic            pix_in_valid,
  output logic            pix_in_ready,
  output logic [PB-1:0]   px_out_data,
  output logic            px_out_valid,
  input  logic            px_out_ready,
  output logic            px_out_last_x,
  output logic            px_out_last_y,
  output logic            done
);

  localparam int FW = PB + 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XB-1:0] col_q, col_d;
  logic [XB-1:0] w_q, w_d, w_cur;
  logic [YB-1:0] row_q, row_d;
  logic [YB-1:0] h_q, h_d, h_cur;
  logic          done_q, done_d;
  logic          accept, first, last_x, last_y, pop;
  logic [PB-1:0] px;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [FW-1:0] head;

  assign pix_in_ready = !fifo_full;
  assign accept       = pix_in_valid && pix_in_ready;
  assign px_out_valid = fifo_cnt != '0;
  assign pop          = px_out_ready && !fifo_empty;
  assign done         = done_q;
  assign {px_out_data, px_out_last_x, px_out_last_y} = head;

  always_comb begin
    first  = (col_q == '0) && (row_q == '0);
    // Frame-start beat sizes itself from live cfg; later beats use the latch.
    w_cur  = first ? XB'(out_dim(32'(cfg_width), KS)) : w_q;
    h_cur  = first ? YB'(out_dim(32'(cfg_height), KS)) : h_q;
    last_x = col_q == w_cur - XB'(1);
    last_y = row_q == h_cur - YB'(1);
    px     = PB'(sat_shift(32'(pix_in), SHIFT, PB));
    col_d  = col_q;
    row_d  = row_q;
    w_d    = w_q;
    h_d    = h_q;
    if (accept) begin
      w_d = w_cur;
      h_d = h_cur;
      if (last_x) begin
        col_d = '0;
        row_d = last_y ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    done_d = done_q;
    if (pop && head[1] && head[0]) done_d = 1'b1;
    else if (accept)               done_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      w_q    <= '0;
      h_q    <= '0;
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      w_q    <= w_d;
      h_q    <= h_d;
      done_q <= done_d;
    end
  end

  outinf_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .wdata_i ({px, last_x, last_y}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule
